// File: rtl/uart_regfile_ctrl_if.sv
// Serial-side signal bundle of the UART register file: line in/out plus the receive error flags.
interface uart_regfile_ctrl_if;
  logic RX_IN;
  logic TX_OUT;
  logic Parity_error;
  logic Framing_error;

  modport master (output RX_IN, input TX_OUT, Parity_error, Framing_error);
  modport slave  (input RX_IN, output TX_OUT, Parity_error, Framing_error);
endinterface

// File: rtl/uart_regfile_ctrl.sv
// UART-driven 16x8 register file: RX deframer, write/read command decoder and TX response framer.
// All logic runs on REF_CLK at PRESCALE clocks per bit.
module uart_regfile_ctrl #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          ADDR_WIDTH = 4,
  parameter int unsigned          PRESCALE   = 8,
  parameter bit                   PAR_EN     = 1'b1,
  parameter bit                   PAR_TYP    = 1'b0,
  parameter logic [DATA_WIDTH-1:0] WR_CMD    = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD    = 8'hBB
) (
  input logic                 REF_CLK,
  input logic                 RST,
  uart_regfile_ctrl_if.slave  bus
);

  localparam int unsigned NumBits = DATA_WIDTH + 2 + (PAR_EN ? 1 : 0);
  localparam int unsigned IdxW    = $clog2(NumBits);
  localparam int unsigned CntW    = $clog2(PRESCALE);

  localparam logic [IdxW-1:0] LastBit = IdxW'(NumBits - 1);
  localparam logic [IdxW-1:0] DataIdx = IdxW'(DATA_WIDTH);
  localparam logic [IdxW-1:0] ParIdx  = IdxW'(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] SampA   = CntW'(PRESCALE / 2 - 1);
  localparam logic [CntW-1:0] SampB   = CntW'(PRESCALE / 2);
  localparam logic [CntW-1:0] SampC   = CntW'(PRESCALE / 2 + 1);

  // ---------------- RX ----------------
  typedef enum logic {RxIdle, RxBits} rx_state_e;

  rx_state_e             rx_state_q;
  logic [CntW-1:0]       rx_cnt_q;
  logic [IdxW-1:0]       rx_idx_q;
  logic [DATA_WIDTH-1:0] rx_shift_q;
  logic                  rx_s0_q, rx_s1_q, rx_prev_q;
  logic                  par_err_q, frm_err_q;
  logic                  rx_valid_q, rx_bad_q;
  logic                  rx_in, rx_maj;

  assign rx_in  = bus.RX_IN;
  // Third sample is taken live so the vote resolves on the last sampling clock.
  assign rx_maj = (rx_s0_q & rx_s1_q) | (rx_s0_q & rx_in) | (rx_s1_q & rx_in);

  always_ff @(posedge REF_CLK or posedge RST) begin
    if (RST) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_s0_q    <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_bad_q   <= 1'b0;
    end else begin
      rx_prev_q  <= rx_in;
      rx_valid_q <= 1'b0;
      rx_bad_q   <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_in) begin
            rx_state_q <= RxBits;
            rx_cnt_q   <= CntW'(1);
            rx_idx_q   <= '0;
          end
        end
        RxBits: begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
          if (rx_cnt_q == SampA) begin
            rx_s0_q <= rx_in;
            if (rx_idx_q == '0) begin
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end
          end
          if (rx_cnt_q == SampB) rx_s1_q <= rx_in;
          if (rx_cnt_q == SampC) begin
            if (rx_idx_q == '0) begin
              if (rx_maj) rx_state_q <= RxIdle;
            end else if (rx_idx_q <= DataIdx) begin
              rx_shift_q <= {rx_maj, rx_shift_q[DATA_WIDTH-1:1]};
            end else if (PAR_EN && rx_idx_q == ParIdx) begin
              par_err_q <= rx_maj != ((^rx_shift_q) ^ PAR_TYP);
            end else begin
              frm_err_q <= ~rx_maj;
            end
          end
          if (rx_cnt_q == CntLast) begin
            rx_cnt_q <= '0;
            if (rx_idx_q == LastBit) begin
              rx_state_q <= RxIdle;
              if (!par_err_q && !frm_err_q) rx_valid_q <= 1'b1;
              else                          rx_bad_q   <= 1'b1;
            end else begin
              rx_idx_q <= rx_idx_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // ---------------- Command decoder + register file ----------------
  typedef enum logic [2:0] {DecIdle, DecWrAddr, DecWrData, DecRdAddr, DecResp} dec_state_e;

  dec_state_e            dec_state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] regs_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_start_q;
  logic                  tx_busy;

  always_ff @(posedge REF_CLK or posedge RST) begin
    if (RST) begin
      dec_state_q <= DecIdle;
      addr_q      <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      for (int i = 0; i < 2**ADDR_WIDTH; i++) regs_q[i] <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (dec_state_q)
        DecIdle: begin
          if (rx_valid_q) begin
            if (rx_shift_q == WR_CMD)      dec_state_q <= DecWrAddr;
            else if (rx_shift_q == RD_CMD) dec_state_q <= DecRdAddr;
          end
        end
        DecWrAddr: begin
          if (rx_valid_q) begin
            addr_q      <= rx_shift_q[ADDR_WIDTH-1:0];
            dec_state_q <= DecWrData;
          end else if (rx_bad_q) begin
            dec_state_q <= DecIdle;
          end
        end
        DecWrData: begin
          if (rx_valid_q) begin
            regs_q[addr_q] <= rx_shift_q;
            dec_state_q    <= DecIdle;
          end else if (rx_bad_q) begin
            dec_state_q <= DecIdle;
          end
        end
        DecRdAddr: begin
          if (rx_valid_q) begin
            tx_data_q   <= regs_q[rx_shift_q[ADDR_WIDTH-1:0]];
            dec_state_q <= DecResp;
          end else if (rx_bad_q) begin
            dec_state_q <= DecIdle;
          end
        end
        DecResp: begin
          if (!tx_busy) begin
            tx_start_q  <= 1'b1;
            dec_state_q <= DecIdle;
          end
        end
        default: dec_state_q <= DecIdle;
      endcase
    end
  end

  // ---------------- TX ----------------
  typedef enum logic {TxIdle, TxBits} tx_state_e;

  tx_state_e             tx_state_q;
  logic [CntW-1:0]       tx_cnt_q;
  logic [IdxW-1:0]       tx_idx_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_par_q, tx_out_q;

  assign tx_busy = (tx_state_q != TxIdle);

  always_ff @(posedge REF_CLK or posedge RST) begin
    if (RST) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          tx_out_q <= 1'b1;
          if (tx_start_q) begin
            tx_state_q <= TxBits;
            tx_out_q   <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= tx_data_q;
            tx_par_q   <= (^tx_data_q) ^ PAR_TYP;
          end
        end
        TxBits: begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
          if (tx_cnt_q == CntLast) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == LastBit) begin
              tx_state_q <= TxIdle;
              tx_out_q   <= 1'b1;
            end else begin
              tx_idx_q <= tx_idx_q + 1'b1;
              // tx_idx_q names the bit just finished; choose the one that follows it.
              if (tx_idx_q < DataIdx) begin
                tx_out_q   <= tx_shift_q[0];
                tx_shift_q <= tx_shift_q >> 1;
              end else if (PAR_EN && tx_idx_q == DataIdx) begin
                tx_out_q <= tx_par_q;
              end else begin
                tx_out_q <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.TX_OUT        = tx_out_q;
  assign bus.Parity_error  = par_err_q;
  assign bus.Framing_error = frm_err_q;

endmodule

// File: tb/tb_uart_regfile_ctrl.sv
// Self-checking bench for uart_regfile_ctrl: UART driver, TX frame monitor with expected-byte queue.
module tb_uart_regfile_ctrl;
  localparam int P = 8;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rd_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_regfile_ctrl_if bus ();

  uart_regfile_ctrl #(.PRESCALE(P)) dut (
    .REF_CLK (clk),
    .RST     (rst),
    .bus     (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         frames = 0;
  bit         mon_active = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // TX monitor: samples mid-bit, compares the whole frame against the next expected byte.
  initial begin
    logic [10:0] fr;
    logic [7:0]  e;
    int          cnt;
    fr  = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && bus.TX_OUT === 1'b0) begin
          mon_active = 1'b1;
          cnt = 0;
        end
        if (mon_active) begin
          if (cnt % P == P / 2) fr[cnt / P] = bus.TX_OUT;
          if (cnt == 10 * P + P / 2) begin
            mon_active = 1'b0;
            frames++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL tx_unexpected: got frame %03h, required no frame", fr);
            end else begin
              e = exp_q.pop_front();
              check("tx_frame", {21'd0, fr}, {21'd0, 1'b1, ^e, e, 1'b0});
            end
          end
          cnt++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1 bus.RX_IN = f[i];
      repeat (P - 1) @(posedge clk);
    end
    @(posedge clk);
    #1 bus.RX_IN = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 * P; k++) begin
      if (exp_q.size() == 0 && !mon_active) break;
      @(posedge clk);
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_frame(8'hAA, 1'b0, 1'b0);
    idle(P);
    send_frame(a, 1'b0, 1'b0);
    idle(P);
    send_frame(d, 1'b0, 1'b0);
    idle(P);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    send_frame(8'hBB, 1'b0, 1'b0);
    idle(P);
    exp_q.push_back(exp);
    send_frame(a, 1'b0, 1'b0);
    wait_drain("rd_done");
    idle(P);
  endtask

  vec_t tbl[5];

  initial begin
    int lat;
    int fr0;
    tbl[0] = '{addr: 8'h01, data: 8'h5A, rd_addr: 8'h01};
    tbl[1] = '{addr: 8'h02, data: 8'hA5, rd_addr: 8'h02};
    tbl[2] = '{addr: 8'h1F, data: 8'hC3, rd_addr: 8'h0F};
    tbl[3] = '{addr: 8'h00, data: 8'hFF, rd_addr: 8'h00};
    tbl[4] = '{addr: 8'h07, data: 8'h01, rd_addr: 8'hF7};

    bus.RX_IN = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_out", bus.TX_OUT, 1);
    check("rst_par_err", bus.Parity_error, 0);
    check("rst_frm_err", bus.Framing_error, 0);
    rst = 1'b0;
    idle(4);

    do_read(8'h03, 8'h00);

    // Write 0x0F to reg 10, then read it back and measure response latency.
    do_write(8'h0A, 8'h0F);
    send_frame(8'hBB, 1'b0, 1'b0);
    idle(P);
    exp_q.push_back(8'h0F);
    send_frame(8'h0A, 1'b0, 1'b0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (bus.TX_OUT === 1'b0) break;
      @(posedge clk);
      #1 lat = k;
    end
    check("tx_latency_le3", (lat >= 1 && lat <= 3), 1);
    wait_drain("rd_0a");
    idle(P);

    for (int i = 0; i < 5; i++) do_write(tbl[i].addr, tbl[i].data);
    for (int i = 0; i < 5; i++) do_read(tbl[i].rd_addr, tbl[i].data);

    // Bad parity on a write command: flag sets and holds, decoder stays idle.
    send_frame(8'hAA, 1'b1, 1'b0);
    idle(2);
    check("par_err_set", bus.Parity_error, 1);
    check("par_err_frm", bus.Framing_error, 0);
    idle(3 * P);
    check("par_err_hold", bus.Parity_error, 1);
    send_frame(8'hBB, 1'b0, 1'b0);
    check("par_err_clear", bus.Parity_error, 0);
    idle(P);
    exp_q.push_back(8'h0F);
    send_frame(8'h0A, 1'b0, 1'b0);
    wait_drain("rd_after_par");
    idle(P);

    // Stop bit low on the write data byte: discarded, register untouched.
    send_frame(8'hAA, 1'b0, 1'b0);
    idle(P);
    send_frame(8'h05, 1'b0, 1'b0);
    idle(P);
    send_frame(8'h77, 1'b0, 1'b1);
    idle(2);
    check("frm_err_set", bus.Framing_error, 1);
    check("frm_err_par", bus.Parity_error, 0);
    idle(P);
    do_read(8'h05, 8'h00);
    check("frm_err_clear", bus.Framing_error, 0);

    fr0 = frames;
    send_frame(8'h55, 1'b0, 1'b0);
    idle(P);
    do_read(8'h0A, 8'h0F);
    check("unknown_cmd_frames", frames - fr0, 1);

    // Two-clock low glitch must not start a frame.
    fr0 = frames;
    @(posedge clk);
    #1 bus.RX_IN = 1'b0;
    idle(2);
    #1 bus.RX_IN = 1'b1;
    idle(4 * P);
    check("glitch_par", bus.Parity_error, 0);
    check("glitch_frm", bus.Framing_error, 0);
    do_read(8'h0A, 8'h0F);
    check("glitch_frames", frames - fr0, 1);

    // Reset in the middle of a response frame.
    send_frame(8'hBB, 1'b0, 1'b0);
    idle(P);
    send_frame(8'h0A, 1'b0, 1'b0);
    lat = 0;
    for (int k = 0; k < 8 && bus.TX_OUT !== 1'b0; k++) begin
      @(posedge clk);
      #1 lat = k;
    end
    check("mid_tx_started", bus.TX_OUT, 0);
    idle(5 * P);
    #1 check("mid_tx_low", bus.TX_OUT, 0);
    #1 rst = 1'b1;
    #1 check("rst_mid_tx_out", bus.TX_OUT, 1);
    idle(3);
    #1 rst = 1'b0;
    idle(2 * P);
    check("rst_mid_quiet", bus.TX_OUT, 1);
    for (int i = 0; i < 5; i++) do_read(tbl[i].rd_addr, 8'h00);
    do_read(8'h0A, 8'h00);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
